// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and the default receive FIFO geometry.
package uart_pkg;

    localparam int BYTE_W                = 8;
    localparam int FIFO_DEPTH_DEFAULT    = 16;
    localparam int FIFO_AF_LEVEL_DEFAULT = 12;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO placed directly behind uart_rx on the same clock.
// First-word fall-through: the head byte is always presented on rd_data,
// and rd_data reads as zero whenever the FIFO is empty.
// A byte that arrives while the FIFO is full (and nothing is being popped)
// is dropped and latches the sticky overrun flag.
// DEPTH must be a power of two in 4..256 so the pointers wrap naturally.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH_DEFAULT,
    parameter int AF_LEVEL = FIFO_AF_LEVEL_DEFAULT
) (
    input  logic                    rx_clk,
    input  logic                    rst,
    input  logic [BYTE_W-1:0]       rx_data,
    input  logic                    rx_valid,
    input  logic                    rd_ready,
    input  logic                    ovr_clr,
    output logic [BYTE_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    almost_full,
    output logic                    overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    // Status flags come from the registered occupancy only, never from
    // same-cycle inputs, so they are glitch-free and reset cleanly.
    assign rd_valid    = (level != '0);
    assign full        = (level == LW'(DEPTH));
    assign almost_full = (level >= LW'(AF_LEVEL));

    // A pop frees a slot on the same edge, so a full FIFO still accepts a
    // byte when the consumer is reading; an empty FIFO cannot pop.
    assign pop  = rd_valid & rd_ready;
    assign push = rx_valid & (~full | pop);
    assign drop = rx_valid & full & ~pop;

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    // Storage is deliberately not reset; an entry written while rst is high
    // is never exposed because level stays at zero and the write pointer
    // does not advance, so the first real push overwrites it.
    always_ff @(posedge rx_clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers, occupancy counter and sticky overrun flag.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            // A drop on the same edge as a clear keeps the flag set so
            // that no lost byte goes unreported.
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a directed vector table, hand
// sequences for fill/overrun/reset corners, and randomized traffic checked
// against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          rx_clk   = 1'b0;
    logic          rst      = 1'b1;
    logic [7:0]    rx_data  = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic          ovr_clr  = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          full;
    logic          almost_full;
    logic          overrun;

    uart_rx_fifo #(
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL)
    ) dut (
        .rx_clk      (rx_clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_ready    (rd_ready),
        .ovr_clr     (ovr_clr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .level       (level),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun)
    );

    always #5 rx_clk = ~rx_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the FIFO contents as a plain queue plus the flag.
    logic [7:0] model_q[$];
    logic       model_ovr = 1'b0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rr;
        logic       oc;
        logic       e_vld;
        logic [7:0] e_data;
        int         e_lvl;
        logic       e_ovr;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        logic [31:0] e_data;
        sz = model_q.size();
        e_data = (sz != 0) ? 32'(model_q[0]) : 32'h0;
        chk({tag, " rd_valid"},    32'(rd_valid),    32'(sz != 0));
        chk({tag, " rd_data"},     32'(rd_data),     e_data);
        chk({tag, " level"},       32'(level),       32'(sz));
        chk({tag, " full"},        32'(full),        32'(sz == DEPTH));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(sz >= AF_LEVEL));
        chk({tag, " overrun"},     32'(overrun),     32'(model_ovr));
    endtask

    // Apply one cycle of inputs, advance the model by the FIFO rules, then
    // compare all outputs just after the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic rr,
                         input logic oc, input string tag);
        int   sz;
        logic mpop;
        logic mpush;
        logic mdrop;
        rx_valid = v;
        rx_data  = d;
        rd_ready = rr;
        ovr_clr  = oc;
        sz    = model_q.size();
        mpop  = rr && (sz > 0);
        mpush = v && ((sz < DEPTH) || mpop);
        mdrop = v && !mpush;
        @(posedge rx_clk);
        #1;
        if (!rst) begin
            if (mpop) void'(model_q.pop_front());
            if (mpush) model_q.push_back(d);
            if (mdrop) model_ovr = 1'b1;
            else if (oc) model_ovr = 1'b0;
        end
        rx_valid = 1'b0;
        rd_ready = 1'b0;
        ovr_clr  = 1'b0;
        check_model(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int guard;
        logic v;
        logic rr;
        logic [7:0] d;

        tbl[0] = '{1'b1, 8'hE3, 1'b0, 1'b0, 1'b1, 8'hE3, 1, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
        tbl[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0};

        // Reset state
        repeat (2) @(posedge rx_clk);
        #1;
        chk("reset rd_valid", 32'(rd_valid), 32'h0);
        chk("reset rd_data", 32'(rd_data), 32'h0);
        chk("reset level", 32'(level), 32'h0);
        chk("reset full", 32'(full), 32'h0);
        chk("reset almost_full", 32'(almost_full), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].oc, "table");
            chk("table rd_valid", 32'(rd_valid), 32'(tbl[i].e_vld));
            chk("table rd_data", 32'(rd_data), 32'(tbl[i].e_data));
            chk("table level", 32'(level), 32'(tbl[i].e_lvl));
            chk("table overrun", 32'(overrun), 32'(tbl[i].e_ovr));
        end

        // Fill to full, watching almost_full and full thresholds
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, "fill");
            chk("fill level", 32'(level), 32'(i + 1));
            chk("fill almost_full", 32'(almost_full), 32'((i + 1) >= 12));
        end
        chk("full flag", 32'(full), 32'h1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, "drop");
        chk("drop overrun", 32'(overrun), 32'h1);
        chk("drop level", 32'(level), 32'd16);

        // Clear coinciding with another drop keeps the flag; a lone clear drops it
        cycle(1'b1, 8'hBB, 1'b0, 1'b1, "clr+drop");
        chk("clr+drop overrun", 32'(overrun), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("clr overrun", 32'(overrun), 32'h0);

        // Drain in order; the dropped bytes must never appear
        for (int i = 0; i < 16; i++) begin
            chk("drain order", 32'(rd_data), 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        chk("drain empty", 32'(rd_valid), 32'h0);

        // Push and pop on the same edge while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "refill");
        chk("full pop head", 32'(rd_data), 32'h20);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "full push+pop");
        chk("full push+pop level", 32'(level), 32'd16);
        chk("full push+pop overrun", 32'(overrun), 32'h0);
        for (int i = 1; i < 16; i++) begin
            chk("drain2 order", 32'(rd_data), 32'(8'h20 + i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2");
        end
        chk("last byte 55", 32'(rd_data), 32'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain2 last");

        // Randomized traffic against the model
        sent  = 0;
        guard = 0;
        while ((sent < 40 || model_q.size() != 0) && guard < 2000) begin
            v  = (sent < 40) && ($urandom_range(0, 3) != 0);
            rr = (sent >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (v && ((model_q.size() < DEPTH) || (rr && model_q.size() > 0))) sent++;
            cycle(v, d, rr, 1'b0, "random");
            guard++;
        end
        chk("random completes", 32'(guard < 2000), 32'h1);

        // Mid-cycle reset with five bytes queued and overrun set
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre-rst fill");
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, "pre-rst drop");
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre-rst drain");
        chk("pre-rst level", 32'(level), 32'd5);
        chk("pre-rst overrun", 32'(overrun), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst rd_valid", 32'(rd_valid), 32'h0);
        chk("async rst rd_data", 32'(rd_data), 32'h0);
        chk("async rst level", 32'(level), 32'h0);
        chk("async rst overrun", 32'(overrun), 32'h0);
        model_q.delete();
        model_ovr = 1'b0;
        cycle(1'b1, 8'h99, 1'b1, 1'b0, "push during rst");
        rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, "post-rst push");
        chk("post-rst data", 32'(rd_data), 32'h3C);
        chk("post-rst level", 32'(level), 32'h1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, "post-rst pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
